video_frame_tx_rgb: RTL and testbench
=====================================

# video_frame_tx_rgb

- Transmitter side of the per-image RGB stream protocol (`vsync` / `de` / r / g / b) that the interpolation scalers consume.
- Reads a `src_img_width` x `src_img_height` frame, pixel by pixel, from a fixed-latency memory read port. Emits it as a frame:
  - vsync framing;
  - contiguous de bursts, one per line;
  - programmable horizontal and vertical blanking.
- Sits in front of the scaler in the clk_in1 domain. Honours a line-granular hold so the scaler's 4-line buffer and row-tag FIFO never overrun.

## Interface
Parameters:
- RD_LAT, 2, read latency in cycles from `rd_en` to valid `rd_data` (1..4).
- ADDR_W, 22, width of the linear pixel read address.

Ports:
- clk_in1  in  1  pixel clock.
- rst_n  in  1  reset: synchronous, active-low, on clk_in1.
- src_img_width  in  11  pixels per line; latched at frame start.
- src_img_height  in  11  lines per frame; latched at frame start.
- h_blank  in  12  de-low cycles between lines; 0 is treated as 1.
- v_front  in  16  vsync-high cycles before the first de; 0 is treated as 1.
- v_back  in  16  vsync-high cycles after the last de; 0 is treated as 1.
- frame_start  in  1  single-cycle request to send one frame.
- line_hold  in  1  downstream not ready; sampled only at line boundaries.
- rd_en  out  1  pixel read strobe.
- rd_addr  out  ADDR_W  linear pixel address; 0 at frame start, +1 per read.
- rd_data  in  24  {r,g,b}, valid RD_LAT cycles after `rd_en`.
- per_img_vsync  out  1  frame-valid.
- per_img_de  out  1  pixel-valid.
- per_img_r / per_img_g / per_img_b  out  8 each  pixel components.
- busy  out  1  high from frame acceptance until the last vsync-high cycle has left the pipeline.

## Operation
- FSM states: S_IDLE, S_V_FRONT, S_LINE_WAIT, S_LINE, S_H_BLANK, S_V_BACK.
- **S_IDLE**
  - `frame_start`=1 with width≠0 and height≠0: latch width, height, h_blank, v_front and v_back; clear `rd_addr`, x_cnt and y_cnt; go to S_V_FRONT.
  - Otherwise `frame_start` is ignored.
- **S_V_FRONT**
  - vsync_c0=1, de_c0=0.
  - Count max(v_front,1) cycles, then go to S_LINE_WAIT.
- **S_LINE_WAIT**
  - vsync_c0=1, de_c0=0.
  - line_hold=0: go to S_LINE. line_hold=1: stay.
- **S_LINE**
  - `rd_en`=1 and de_c0=1 every cycle. x_cnt and `rd_addr` increment each cycle.
  - x_cnt==width−1: clear x_cnt, increment y_cnt.
    - Not the last line: go to S_H_BLANK.
    - Last line: go to S_V_BACK.
  - Lines are never interrupted; `line_hold` is ignored inside a line.
- **S_H_BLANK**
  - Count max(h_blank,1) cycles, then go to S_LINE_WAIT.
- **S_V_BACK**
  - Count max(v_back,1) cycles with vsync_c0=1, then go to S_IDLE (vsync_c0=0).
- `frame_start` in any state other than S_IDLE is dropped; there is no queueing.
- Blanking counters are 16 bits and load with value−1. `rd_addr` wraps modulo 2^ADDR_W.

## Timing
- vsync_c0 and de_c0 go through an RD_LAT-stage shift register. Stage RD_LAT drives the output registers together with the captured `rd_data`.
- Output latency is therefore RD_LAT+1 cycles from the `rd_en` cycle to the `per_img_de` cycle, with pixel data aligned to it.
- `frame_start` sampled in cycle T gives state S_V_FRONT in T+1.
- First `per_img_vsync` high is at T+1+RD_LAT+1.
- Reset values: `rd_en`, `rd_addr`, `per_img_vsync`, `per_img_de`, r/g/b and `busy` are all 0. The shift register clears and the FSM goes to S_IDLE.
- Reset mid-frame: every output is 0 on the cycle after `rst_n` is sampled low. The frame is abandoned, not resumed.
- `busy` = (state≠S_IDLE) OR (any vsync pipeline stage = 1).
- A new `frame_start` is accepted in the first S_IDLE cycle. The gap between frames is therefore ≥1 cycle of vsync low at the output.

## Structure
- Shared video package holds:
  - state encoding constants;
  - the pixel width constant (24);
  - the 11-bit image dimension width used by all scaler blocks.
- One sub-module: `video_sig_delay` — a parameterised depth/width shift register with synchronous reset. It carries the {vsync,de} pipeline and can be reused by the scalers.
- Data path (`rd_data` to r/g/b) needs no reset.

## Test plan
- **Basic frame.** width=4, height=2, h_blank=3, v_front=2, v_back=2, RD_LAT=2; memory returns data=address.
  - Expect `per_img_vsync` high for 2+4+3+4+2 = 15 cycles.
  - Expect de bursts carrying pixels 0–3 and 4–7, with exactly 3 de-low cycles between them.
- **line_hold.** Same frame; assert `line_hold` for 10 cycles during S_H_BLANK.
  - Expect the second burst to start 10 cycles later.
  - Expect vsync to stay high throughout.
  - Expect the first line to be unaffected.
- **Zero blanking.** h_blank=0, v_front=0, v_back=0.
  - Expect exactly 1 cycle of de low between lines, before the first line and after the last line, all inside vsync.
- **Illegal and duplicate requests.**
  - width=0 with `frame_start`: `busy` stays 0, no `rd_en`.
  - `frame_start` pulsed mid-frame: no second frame; `rd_addr` sequence is unchanged.
- **Reset mid-line.** Drop `rst_n` during the line-1 burst of a 1920x1080 frame.
  - Next cycle: vsync, de and `busy` are 0.
  - A subsequent `frame_start` restarts at `rd_addr`=0.
- **Back-to-back frames.** Issue `frame_start` in the first S_IDLE cycle after a frame.
  - Expect 1 vsync-low cycle between frames.
  - Expect `rd_addr` to restart at 0.

Source files
------------

// File: rtl/video_frame_tx_rgb_pkg.sv
// Shared definitions for the per-image RGB stream blocks (frame transmitter and scalers).
package video_frame_tx_rgb_pkg;

  localparam int PIX_W     = 24;
  localparam int IMG_DIM_W = 11;
  localparam int BLANK_W   = 16;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_V_FRONT   = 3'd1,
    S_LINE_WAIT = 3'd2,
    S_LINE      = 3'd3,
    S_H_BLANK   = 3'd4,
    S_V_BACK    = 3'd5
  } tx_state_e;

  // Blanking counters count down to zero, so a request of N cycles loads N-1; 0 behaves as 1.
  function automatic logic [BLANK_W-1:0] blank_load(input logic [BLANK_W-1:0] cycles);
    return (cycles == '0) ? '0 : cycles - BLANK_W'(1);
  endfunction

endpackage

// File: rtl/video_sig_delay.sv
// Parameterised depth x width shift register with synchronous reset; all stages exposed as taps.
module video_sig_delay #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2
) (
  input  logic                        clk_in1,
  input  logic                        rst_n,
  input  logic [WIDTH-1:0]            din,
  output logic [DEPTH-1:0][WIDTH-1:0] taps,
  output logic [WIDTH-1:0]            dout
);

  // NOTE: non-blocking (<=) so each stage takes the previous stage's value from before the edge.
  always_ff @(posedge clk_in1) begin
    if (!rst_n) begin
      taps <= '0;
    end else begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/video_frame_tx_rgb.sv
// Frame transmitter: reads a stored image from a fixed-latency port and emits vsync/de/RGB.
module video_frame_tx_rgb
  import video_frame_tx_rgb_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int ADDR_W = 22
) (
  input  logic                 clk_in1,
  input  logic                 rst_n,
  input  logic [IMG_DIM_W-1:0] src_img_width,
  input  logic [IMG_DIM_W-1:0] src_img_height,
  input  logic [11:0]          h_blank,
  input  logic [15:0]          v_front,
  input  logic [15:0]          v_back,
  input  logic                 frame_start,
  input  logic                 line_hold,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [PIX_W-1:0]     rd_data,
  output logic                 per_img_vsync,
  output logic                 per_img_de,
  output logic [7:0]           per_img_r,
  output logic [7:0]           per_img_g,
  output logic [7:0]           per_img_b,
  output logic                 busy
);

  tx_state_e              state, state_nxt;
  logic [IMG_DIM_W-1:0]   width_q, height_q, x_cnt, y_cnt;
  logic [11:0]            h_blank_q;
  logic [BLANK_W-1:0]     v_back_q, blank_cnt;
  logic                   start_ok, blank_done, line_end, last_line;
  logic                   vsync_c0, de_c0;
  logic [RD_LAT-1:0][1:0] sig_taps;
  logic [1:0]             sig_out;

  assign start_ok   = frame_start && (src_img_width != '0) && (src_img_height != '0);
  assign blank_done = (blank_cnt == '0);
  assign line_end   = (x_cnt == width_q - IMG_DIM_W'(1));
  assign last_line  = (y_cnt == height_q - IMG_DIM_W'(1));

  always_ff @(posedge clk_in1) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // The wait state is only entered when line_hold is high at a line boundary,
  // so an unheld frame adds no cycles between blanking and the next line.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    vsync_c0  = 1'b1;
    de_c0     = 1'b0;
    rd_en     = 1'b0;
    case (state)
      S_IDLE: begin
        vsync_c0 = 1'b0;
        if (start_ok) state_nxt = S_V_FRONT;
      end
      S_V_FRONT, S_H_BLANK: begin
        if (blank_done) state_nxt = line_hold ? S_LINE_WAIT : S_LINE;
      end
      S_LINE_WAIT: begin
        if (!line_hold) state_nxt = S_LINE;
      end
      S_LINE: begin
        de_c0 = 1'b1;
        rd_en = 1'b1;
        if (line_end) state_nxt = last_line ? S_V_BACK : S_H_BLANK;
      end
      S_V_BACK: begin
        if (blank_done) state_nxt = S_IDLE;
      end
      default: begin
        vsync_c0  = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in1) begin
    if (!rst_n) begin
      width_q   <= '0;
      height_q  <= '0;
      h_blank_q <= '0;
      v_back_q  <= '0;
      blank_cnt <= '0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      rd_addr   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            width_q   <= src_img_width;
            height_q  <= src_img_height;
            h_blank_q <= h_blank;
            v_back_q  <= v_back;
            blank_cnt <= blank_load(v_front);
            x_cnt     <= '0;
            y_cnt     <= '0;
            rd_addr   <= '0;
          end
        end
        S_V_FRONT, S_H_BLANK, S_V_BACK: begin
          if (!blank_done) blank_cnt <= blank_cnt - BLANK_W'(1);
        end
        S_LINE: begin
          rd_addr <= rd_addr + ADDR_W'(1);
          if (line_end) begin
            x_cnt     <= '0;
            y_cnt     <= y_cnt + IMG_DIM_W'(1);
            blank_cnt <= last_line ? blank_load(v_back_q) : blank_load({4'd0, h_blank_q});
          end else begin
            x_cnt <= x_cnt + IMG_DIM_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // {vsync, de} travel alongside the memory latency so they line up with rd_data.
  video_sig_delay #(
    .DEPTH (RD_LAT),
    .WIDTH (2)
  ) u_sig_delay (
    .clk_in1 (clk_in1),
    .rst_n   (rst_n),
    .din     ({vsync_c0, de_c0}),
    .taps    (sig_taps),
    .dout    (sig_out)
  );

  // NOTE: the pixel registers are reset only so r/g/b read 0 after reset; they load on de alone.
  always_ff @(posedge clk_in1) begin
    if (!rst_n) begin
      per_img_vsync <= 1'b0;
      per_img_de    <= 1'b0;
      per_img_r     <= '0;
      per_img_g     <= '0;
      per_img_b     <= '0;
    end else begin
      per_img_vsync <= sig_out[1];
      per_img_de    <= sig_out[0];
      if (sig_out[0]) {per_img_r, per_img_g, per_img_b} <= rd_data;
    end
  end

  // de is never set without vsync, so OR-ing every tap equals OR-ing the vsync taps.
  assign busy = (state != S_IDLE) || (|sig_taps);

endmodule

// File: tb/tb_video_frame_tx_rgb.sv
// Directed bench for video_frame_tx_rgb: per-cycle table for one frame plus framing scenarios.
module tb_video_frame_tx_rgb;

  localparam int RD_LAT = 2;
  localparam int ADDR_W = 22;
  localparam int NMAX   = 64;

  logic              clk_in1;
  logic              rst_n;
  logic [10:0]       src_img_width, src_img_height;
  logic [11:0]       h_blank;
  logic [15:0]       v_front, v_back;
  logic              frame_start, line_hold;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [23:0]       rd_data;
  logic              per_img_vsync, per_img_de;
  logic [7:0]        per_img_r, per_img_g, per_img_b;
  logic              busy;

  video_frame_tx_rgb #(.RD_LAT(RD_LAT), .ADDR_W(ADDR_W)) dut (
    .clk_in1        (clk_in1),
    .rst_n          (rst_n),
    .src_img_width  (src_img_width),
    .src_img_height (src_img_height),
    .h_blank        (h_blank),
    .v_front        (v_front),
    .v_back         (v_back),
    .frame_start    (frame_start),
    .line_hold      (line_hold),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .per_img_vsync  (per_img_vsync),
    .per_img_de     (per_img_de),
    .per_img_r      (per_img_r),
    .per_img_g      (per_img_g),
    .per_img_b      (per_img_b),
    .busy           (busy)
  );

  initial clk_in1 = 1'b0;
  always #5 clk_in1 = ~clk_in1;

  // Memory model: data equals address, returned RD_LAT cycles after the read.
  logic [23:0] mem_pipe [RD_LAT];
  always @(posedge clk_in1) begin
    mem_pipe[0] <= 24'(rd_addr);
    for (int i = 1; i < RD_LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign rd_data = mem_pipe[RD_LAT-1];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Per-cycle trace; index k is cycles after the cycle frame_start was presented.
  logic              tr_vs   [0:NMAX];
  logic              tr_de   [0:NMAX];
  logic              tr_rden [0:NMAX];
  logic              tr_busy [0:NMAX];
  logic [23:0]       tr_pix  [0:NMAX];
  logic [ADDR_W-1:0] tr_addr [0:NMAX];

  task automatic sample(input int k);
    tr_vs[k]   = per_img_vsync;
    tr_de[k]   = per_img_de;
    tr_rden[k] = rd_en;
    tr_busy[k] = busy;
    tr_pix[k]  = {per_img_r, per_img_g, per_img_b};
    tr_addr[k] = rd_addr;
  endtask

  task automatic run_frame(input int w, input int h, input int hb, input int vf, input int vb,
                           input int n, input int hold_from, input int hold_len, input int fs_at);
    src_img_width  = 11'(w);
    src_img_height = 11'(h);
    h_blank        = 12'(hb);
    v_front        = 16'(vf);
    v_back         = 16'(vb);
    @(negedge clk_in1);
    sample(0);
    frame_start = 1'b1;
    line_hold   = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk_in1);
      sample(k);
      frame_start = (k == fs_at);
      line_hold   = (k >= hold_from) && (k < hold_from + hold_len);
    end
    frame_start = 1'b0;
    line_hold   = 1'b0;
  endtask

  int vs_cnt, vs_first, vs_last, vs_rises, nb, any_busy, any_rden;
  int b_start [8];
  int b_end   [8];
  int pix_q  [$];
  int addr_q [$];

  task automatic analyse(input int n);
    vs_cnt = 0; vs_first = -1; vs_last = -1; vs_rises = 0; nb = 0; any_busy = 0; any_rden = 0;
    for (int i = 0; i < 8; i++) begin b_start[i] = -1; b_end[i] = -1; end
    pix_q.delete();
    addr_q.delete();
    for (int k = 0; k <= n; k++) begin
      if (tr_busy[k]) any_busy = 1;
      if (tr_vs[k]) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = k;
        vs_last = k;
        if (k > 0 && !tr_vs[k-1]) vs_rises++;
      end
      if (tr_de[k]) begin
        pix_q.push_back(int'(tr_pix[k]));
        if (k == 0 || !tr_de[k-1]) begin
          if (nb < 8) b_start[nb] = k;
          nb++;
        end
        if (nb <= 8) b_end[nb-1] = k;
      end
      if (tr_rden[k]) begin
        any_rden = 1;
        addr_q.push_back(int'(tr_addr[k]));
      end
    end
  endtask

  // Number of entries that break the repeating 0..modv-1 sequence.
  function automatic int seq_errs(input int q[$], input int modv);
    int e = 0;
    foreach (q[i]) if (q[i] != (i % modv)) e++;
    return e;
  endfunction

  typedef struct {
    int                k;
    logic              vs;
    logic              de;
    logic [23:0]       pix;
    logic              rden;
    logic [ADDR_W-1:0] addr;
    logic              bsy;
  } vec_t;

  vec_t vecs [13];

  initial begin
    // 4x2, h_blank 3, v_front 2, v_back 2: frame_start in cycle 0, state timeline
    // V_FRONT 1-2, LINE 3-6, H_BLANK 7-9, LINE 10-13, V_BACK 14-15; outputs lag 3 cycles.
    vecs[0]  = '{1,  1'b0, 1'b0, 24'd0, 1'b0, 22'd0, 1'b1};
    vecs[1]  = '{3,  1'b0, 1'b0, 24'd0, 1'b1, 22'd0, 1'b1};
    vecs[2]  = '{4,  1'b1, 1'b0, 24'd0, 1'b1, 22'd1, 1'b1};
    vecs[3]  = '{6,  1'b1, 1'b1, 24'd0, 1'b1, 22'd3, 1'b1};
    vecs[4]  = '{7,  1'b1, 1'b1, 24'd1, 1'b0, 22'd4, 1'b1};
    vecs[5]  = '{9,  1'b1, 1'b1, 24'd3, 1'b0, 22'd4, 1'b1};
    vecs[6]  = '{10, 1'b1, 1'b0, 24'd0, 1'b1, 22'd4, 1'b1};
    vecs[7]  = '{13, 1'b1, 1'b1, 24'd4, 1'b1, 22'd7, 1'b1};
    vecs[8]  = '{14, 1'b1, 1'b1, 24'd5, 1'b0, 22'd8, 1'b1};
    vecs[9]  = '{16, 1'b1, 1'b1, 24'd7, 1'b0, 22'd8, 1'b1};
    vecs[10] = '{17, 1'b1, 1'b0, 24'd0, 1'b0, 22'd8, 1'b1};
    vecs[11] = '{18, 1'b1, 1'b0, 24'd0, 1'b0, 22'd8, 1'b0};
    vecs[12] = '{19, 1'b0, 1'b0, 24'd0, 1'b0, 22'd8, 1'b0};

    rst_n = 1'b0; frame_start = 1'b0; line_hold = 1'b0;
    src_img_width = 11'd4; src_img_height = 11'd2;
    h_blank = 12'd3; v_front = 16'd2; v_back = 16'd2;
    repeat (5) @(negedge clk_in1);
    check("reset rd_en", rd_en, 0);
    check("reset rd_addr", rd_addr, 0);
    check("reset vsync", per_img_vsync, 0);
    check("reset de", per_img_de, 0);
    check("reset rgb", {per_img_r, per_img_g, per_img_b}, 0);
    check("reset busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk_in1);

    // Basic frame, compared cycle by cycle against the table.
    run_frame(4, 2, 3, 2, 2, 24, 0, 0, -1);
    foreach (vecs[i]) begin
      check($sformatf("basic k=%0d vsync", vecs[i].k), tr_vs[vecs[i].k], vecs[i].vs);
      check($sformatf("basic k=%0d de", vecs[i].k), tr_de[vecs[i].k], vecs[i].de);
      check($sformatf("basic k=%0d rd_en", vecs[i].k), tr_rden[vecs[i].k], vecs[i].rden);
      check($sformatf("basic k=%0d rd_addr", vecs[i].k), tr_addr[vecs[i].k], vecs[i].addr);
      check($sformatf("basic k=%0d busy", vecs[i].k), tr_busy[vecs[i].k], vecs[i].bsy);
      if (vecs[i].de) check($sformatf("basic k=%0d pixel", vecs[i].k), tr_pix[vecs[i].k], vecs[i].pix);
    end
    analyse(24);
    check("basic vsync cycles", vs_cnt, 15);
    check("basic bursts", nb, 2);
    check("basic h gap", b_start[1] - b_end[0] - 1, 3);
    check("basic pixel seq errs", seq_errs(pix_q, 8), 0);
    check("basic pixel count", pix_q.size(), 8);

    // line_hold high from the last H_BLANK cycle for 10 cycles: second line 10 cycles late.
    run_frame(4, 2, 3, 2, 2, 36, 9, 10, -1);
    analyse(36);
    check("hold first burst start", b_start[0], 6);
    check("hold first burst end", b_end[0], 9);
    check("hold burst spacing", b_start[1] - b_start[0], 17);
    check("hold vsync cycles", vs_cnt, 25);
    check("hold vsync rises", vs_rises, 1);
    check("hold pixel seq errs", seq_errs(pix_q, 8), 0);

    // Zero blanking: every blank collapses to a single cycle.
    run_frame(4, 2, 0, 0, 0, 20, 0, 0, -1);
    analyse(20);
    check("zero vsync cycles", vs_cnt, 11);
    check("zero bursts", nb, 2);
    check("zero front gap", b_start[0] - vs_first, 1);
    check("zero h gap", b_start[1] - b_end[0] - 1, 1);
    check("zero back gap", vs_last - b_end[1], 1);

    // Illegal dimensions are ignored.
    run_frame(0, 2, 3, 2, 2, 12, 0, 0, -1);
    analyse(12);
    check("width0 busy", any_busy, 0);
    check("width0 rd_en", any_rden, 0);
    run_frame(4, 0, 3, 2, 2, 12, 0, 0, -1);
    analyse(12);
    check("height0 busy", any_busy, 0);
    check("height0 vsync", vs_cnt, 0);

    // Duplicate request mid-frame is dropped.
    run_frame(4, 2, 3, 2, 2, 26, 0, 0, 8);
    analyse(26);
    check("dup read count", addr_q.size(), 8);
    check("dup addr seq errs", seq_errs(addr_q, 8), 0);
    check("dup vsync rises", vs_rises, 1);
    check("dup vsync cycles", vs_cnt, 15);

    // Back-to-back: second request in the first idle cycle (k=16).
    run_frame(4, 2, 3, 2, 2, 40, 0, 0, 16);
    analyse(40);
    check("b2b vsync rises", vs_rises, 2);
    check("b2b vsync low gap", vs_last - vs_first + 1 - vs_cnt, 1);
    check("b2b read count", addr_q.size(), 16);
    check("b2b second addr start", addr_q[8], 0);
    check("b2b addr seq errs", seq_errs(addr_q, 8), 0);
    check("b2b pixel seq errs", seq_errs(pix_q, 8), 0);

    // Reset during line 1 of a 1920x1080 frame (line 1 reads start in cycle 1926).
    src_img_width = 11'd1920; src_img_height = 11'd1080;
    h_blank = 12'd3; v_front = 16'd2; v_back = 16'd2;
    @(negedge clk_in1);
    frame_start = 1'b1;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk_in1);
      if (k == 1) frame_start = 1'b0;
    end
    check("big line1 rd_en", rd_en, 1);
    check("big line1 rd_addr", rd_addr, 1994);
    check("big line1 de", per_img_de, 1);
    check("big line1 pixel", {per_img_r, per_img_g, per_img_b}, 1991);
    rst_n = 1'b0;
    @(negedge clk_in1);
    check("midreset vsync", per_img_vsync, 0);
    check("midreset de", per_img_de, 0);
    check("midreset busy", busy, 0);
    check("midreset rd_en", rd_en, 0);
    check("midreset rd_addr", rd_addr, 0);
    rst_n = 1'b1;
    run_frame(4, 2, 3, 2, 2, 24, 0, 0, -1);
    analyse(24);
    check("restart read count", addr_q.size(), 8);
    check("restart first addr", addr_q[0], 0);
    check("restart vsync cycles", vs_cnt, 15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
